// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector result drain stage.
package mvm_pkg;

   localparam int DEF_NUM_BIT = 16;
   localparam int DEF_NUM_DIM = 8;

   typedef logic signed [DEF_NUM_BIT-1:0] elem_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      STREAM = 2'b01
   } state_t;

   localparam elem_t ELEM_MAX = {1'b0, {(DEF_NUM_BIT-1){1'b1}}};
   localparam elem_t ELEM_MIN = {1'b1, {(DEF_NUM_BIT-1){1'b0}}};

   // Signed add with one guard bit, clamped to the elem_t range.
   function automatic elem_t sat_add(elem_t a, elem_t b);
      logic [DEF_NUM_BIT:0] s;
      s = {a[DEF_NUM_BIT-1], a} + {b[DEF_NUM_BIT-1], b};
      if (s[DEF_NUM_BIT] != s[DEF_NUM_BIT-1]) begin
         return s[DEF_NUM_BIT] ? ELEM_MIN : ELEM_MAX;
      end
      return s[DEF_NUM_BIT-1:0];
   endfunction

endpackage

// File: rtl/mvm_post_elem.sv
// Per-element post-processing: bias add, signed saturation, optional ReLU.
module mvm_post_elem
   import mvm_pkg::*;
#(
   parameter int NUM_BIT = DEF_NUM_BIT
) (
   input  logic [NUM_BIT-1:0] y,
   input  logic [NUM_BIT-1:0] bias,
   input  logic               relu_en,
   output logic [NUM_BIT-1:0] elem
);

   logic [NUM_BIT-1:0] sat;

   if (NUM_BIT == DEF_NUM_BIT) begin : g_pkg_width
      assign sat = sat_add(elem_t'(y), elem_t'(bias));
   end else begin : g_any_width
      logic [NUM_BIT:0] sum;
      assign sum = {y[NUM_BIT-1], y} + {bias[NUM_BIT-1], bias};

      // Clamp when the guard bit disagrees with the result sign bit.
      always_comb begin
         sat = sum[NUM_BIT-1:0];
         if (sum[NUM_BIT] != sum[NUM_BIT-1]) begin
            sat = sum[NUM_BIT] ? {1'b1, {(NUM_BIT-1){1'b0}}}
                               : {1'b0, {(NUM_BIT-1){1'b1}}};
         end
      end
   end

   assign elem = (relu_en && sat[NUM_BIT-1]) ? '0 : sat;

endmodule

// File: rtl/mvm_result_drain.sv
// Captures a finished accumulator vector on the falling edge of isAcc,
// post-processes every element in parallel, then streams the elements out
// one per valid/ready transfer. Results arriving mid-stream are dropped and
// flagged through a sticky overrun bit.
module mvm_result_drain
   import mvm_pkg::*;
#(
   parameter int NUM_BIT = DEF_NUM_BIT,
   parameter int NUM_DIM = DEF_NUM_DIM,
   parameter int IDX_W   = $clog2(NUM_DIM)
) (
   input  logic                       i_clk_topMvm,
   input  logic                       i_rst_topMvm,
   input  logic                       i_isAcc,
   input  logic [NUM_DIM*NUM_BIT-1:0] i_y_vector,
   input  logic [NUM_DIM*NUM_BIT-1:0] i_bias,
   input  logic                       i_relu_en,
   input  logic                       i_ready,
   input  logic                       i_clear_overrun,
   output logic [NUM_BIT-1:0]         o_data,
   output logic                       o_valid,
   output logic [IDX_W-1:0]           o_idx,
   output logic                       o_last,
   output logic                       o_busy,
   output logic                       o_overrun
);

   state_t             state_q;
   state_t             state_d;
   logic               isacc_d;
   logic               capture;
   logic               accept;
   logic               xfer;
   logic               at_last;
   logic [IDX_W-1:0]   idx_q;
   logic               overrun_q;
   logic [NUM_BIT-1:0] buf_q     [NUM_DIM];
   logic [NUM_BIT-1:0] post_elem [NUM_DIM];

   for (genvar g = 0; g < NUM_DIM; g++) begin : g_post
      mvm_post_elem #(
         .NUM_BIT (NUM_BIT)
      ) u_post (
         .y       (i_y_vector[g*NUM_BIT +: NUM_BIT]),
         .bias    (i_bias[g*NUM_BIT +: NUM_BIT]),
         .relu_en (i_relu_en),
         .elem    (post_elem[g])
      );
   end

   assign capture = isacc_d & ~i_isAcc;
   assign accept  = capture && (state_q == IDLE);
   assign at_last = (idx_q == IDX_W'(NUM_DIM - 1));
   assign xfer    = o_valid & i_ready;

   // Delayed busy flag for the done (1->0) edge detect.
   always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
      if (i_rst_topMvm) isacc_d <= 1'b0;
      else              isacc_d <= i_isAcc;
   end

   // FSM state register.
   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
      if (i_rst_topMvm) state_q <= IDLE;
      else              state_q <= state_d;
   end

   // FSM next state: start on an accepted capture, finish on the last transfer.
   // NOTE: the default at the top of every always_comb keeps it from inferring a latch.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = accept ? STREAM : IDLE;
         STREAM:  state_d = (xfer && at_last) ? IDLE : STREAM;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: everything is zero outside STREAM.
   always_comb begin
      o_valid = 1'b0;
      o_busy  = 1'b0;
      o_data  = '0;
      o_idx   = '0;
      o_last  = 1'b0;
      if (state_q == STREAM) begin
         o_valid = 1'b1;
         o_busy  = 1'b1;
         o_data  = buf_q[idx_q];
         o_idx   = idx_q;
         o_last  = at_last;
      end
   end

   // Element index: cleared on capture, advanced on each transfer.
   always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
      if (i_rst_topMvm)      idx_q <= '0;
      else if (accept)       idx_q <= '0;
      else if (xfer)         idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
   end

   // Result buffer: loads every processed element in the capture cycle.
   // NOTE: the buffer is reset so a reset mid-stream leaves no stale vector behind.
   always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
      if (i_rst_topMvm) begin
         for (int i = 0; i < NUM_DIM; i++) buf_q[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_DIM; i++) buf_q[i] <= post_elem[i];
      end
   end

   // Sticky overrun: a capture outside IDLE sets it, set beats clear.
   always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
      if (i_rst_topMvm)                      overrun_q <= 1'b0;
      else if (capture && state_q != IDLE)   overrun_q <= 1'b1;
      else if (i_clear_overrun)              overrun_q <= 1'b0;
   end

   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Directed bench for mvm_result_drain (NUM_BIT=16, NUM_DIM=4) with an
// expected-element queue filled at capture and drained on each transfer.
module tb_mvm_result_drain;

   localparam int NB = 16;
   localparam int ND = 4;

   typedef struct {
      logic signed [NB-1:0] data;
      logic [1:0]           idx;
      logic                 last;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              i_isAcc;
   logic [ND*NB-1:0]  i_y_vector;
   logic [ND*NB-1:0]  i_bias;
   logic              i_relu_en;
   logic              i_ready;
   logic              i_clear_overrun;
   logic [NB-1:0]     o_data;
   logic              o_valid;
   logic [1:0]        o_idx;
   logic              o_last;
   logic              o_busy;
   logic              o_overrun;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];

   logic          hold_pending = 1'b0;
   logic [NB-1:0] hold_data;
   logic [1:0]    hold_idx;

   mvm_result_drain #(
      .NUM_BIT (NB),
      .NUM_DIM (ND)
   ) dut (
      .i_clk_topMvm    (clk),
      .i_rst_topMvm    (rst),
      .i_isAcc         (i_isAcc),
      .i_y_vector      (i_y_vector),
      .i_bias          (i_bias),
      .i_relu_en       (i_relu_en),
      .i_ready         (i_ready),
      .i_clear_overrun (i_clear_overrun),
      .o_data          (o_data),
      .o_valid         (o_valid),
      .o_idx           (o_idx),
      .o_last          (o_last),
      .o_busy          (o_busy),
      .o_overrun       (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [NB-1:0] model(input int y, input int b, input bit relu);
      int s;
      s = y + b;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return NB'(s);
   endfunction

   // Check stability / scoreboard for the coming edge, then advance one cycle.
   task automatic step();
      exp_t e;
      if (hold_pending) begin
         check("hold_data", o_data, hold_data);
         check("hold_idx", o_idx, hold_idx);
         hold_pending = 1'b0;
      end
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_xfer", o_valid, 1'b0);
         end else begin
            e = q.pop_front();
            check("data", $signed(o_data), e.data);
            check("idx", o_idx, e.idx);
            check("last", o_last, e.last);
         end
      end else if (o_valid === 1'b1) begin
         hold_data    = o_data;
         hold_idx     = o_idx;
         hold_pending = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Busy pulse then done edge; the capture edge is the second step.
   task automatic capture(input int y[ND], input int b[ND], input bit relu,
                          input bit accept, input bit clr);
      i_isAcc = 1'b1;
      step();
      i_isAcc = 1'b0;
      i_relu_en = relu;
      i_clear_overrun = clr;
      for (int i = 0; i < ND; i++) begin
         i_y_vector[i*NB +: NB] = NB'(y[i]);
         i_bias[i*NB +: NB]     = NB'(b[i]);
      end
      if (accept) begin
         for (int i = 0; i < ND; i++)
            q.push_back('{data: model(y[i], b[i], relu), idx: 2'(i), last: (i == ND-1)});
      end
      step();
      i_clear_overrun = 1'b0;
      i_y_vector = {$urandom, $urandom};
      i_bias     = {$urandom, $urandom};
      i_relu_en  = ~relu;
      if (accept) begin
         check("cap_valid", o_valid, 1'b1);
         check("cap_idx", o_idx, 2'd0);
      end
   endtask

   task automatic drain(input int exp_cycles);
      int cnt = 0;
      while (q.size() > 0 && cnt < 100) begin
         step();
         cnt++;
      end
      check("drain_left", q.size(), 0);
      if (exp_cycles >= 0) check("drain_cycles", cnt, exp_cycles);
      check("busy_after", o_busy, 1'b0);
      check("valid_after", o_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      i_isAcc = 1'b0;
      i_y_vector = '0;
      i_bias = '0;
      i_relu_en = 1'b0;
      i_ready = 1'b1;
      i_clear_overrun = 1'b0;
      @(posedge clk);
      #1;
      check("rst_valid", o_valid, 1'b0);
      check("rst_data", o_data, 16'd0);
      check("rst_idx", o_idx, 2'd0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_overrun", o_overrun, 1'b0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("no_cap_after_rst", o_valid, 1'b0);
      check("no_busy_after_rst", o_busy, 1'b0);

      // Basic drain
      capture('{100, -5, 7, 0}, '{-30, 0, 3, 0}, 1'b0, 1'b1, 1'b0);
      drain(4);

      // Saturation, then ReLU
      capture('{32767, -32768, -32768, -5}, '{10, -1, -1, 0}, 1'b0, 1'b1, 1'b0);
      drain(4);
      capture('{32767, -32768, -32768, -5}, '{10, -1, -1, 0}, 1'b1, 1'b1, 1'b0);
      drain(4);

      // Backpressure
      i_ready = 1'b0;
      capture('{100, -5, 7, 0}, '{-30, 0, 3, 0}, 1'b0, 1'b1, 1'b0);
      repeat (3) step();
      for (int c = 0; c < 40 && q.size() > 0; c++) begin
         i_ready = (c % 2 == 0);
         step();
      end
      check("bp_left", q.size(), 0);
      i_ready = 1'b1;
      step();
      check("bp_busy_after", o_busy, 1'b0);

      // Overrun while idx=1
      capture('{1, 2, 3, 4}, '{10, 20, 30, 40}, 1'b0, 1'b1, 1'b0);
      capture('{-9, -9, -9, -9}, '{0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
      check("ovr_set", o_overrun, 1'b1);
      check("ovr_idx", o_idx, 2'd2);
      drain(2);
      i_clear_overrun = 1'b1;
      step();
      i_clear_overrun = 1'b0;
      check("ovr_cleared", o_overrun, 1'b0);

      // Set and clear in the same cycle
      capture('{5, 6, 7, 8}, '{-1, -1, -1, -1}, 1'b0, 1'b1, 1'b0);
      capture('{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0, 1'b1);
      check("ovr_set_wins", o_overrun, 1'b1);
      drain(2);
      i_clear_overrun = 1'b1;
      step();
      i_clear_overrun = 1'b0;
      check("ovr_cleared2", o_overrun, 1'b0);

      // Done coinciding with the last transfer is still an overrun
      capture('{-100, 200, -300, 400}, '{0, 0, 0, 0}, 1'b1, 1'b1, 1'b0);
      step();
      step();
      capture('{7, 7, 7, 7}, '{0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
      check("last_ovr", o_overrun, 1'b1);
      check("last_ovr_idle", o_valid, 1'b0);
      check("last_ovr_q", q.size(), 0);

      // Asynchronous reset mid-stream at idx=2
      capture('{11, 22, 33, 44}, '{1, 1, 1, 1}, 1'b0, 1'b1, 1'b0);
      step();
      step();
      check("pre_rst_idx", o_idx, 2'd2);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", o_valid, 1'b0);
      check("arst_data", o_data, 16'd0);
      check("arst_idx", o_idx, 2'd0);
      check("arst_last", o_last, 1'b0);
      check("arst_busy", o_busy, 1'b0);
      check("arst_overrun", o_overrun, 1'b0);
      q.delete();
      hold_pending = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step();
      check("no_resume", o_valid, 1'b0);
      capture('{100, -5, 7, 0}, '{-30, 0, 3, 0}, 1'b0, 1'b1, 1'b0);
      drain(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mvm_result_drain.md
# mvm_result_drain

Downstream stage of the matrix-vector accumulator. It watches the accumulator's done indication and captures the finished NUM_DIM-element result vector in one cycle. Each element gets a per-element bias add, signed saturation and optional ReLU. The processed vector is then streamed out one element per transfer over a valid/ready handshake to the next layer's input buffer.

## Interface
- NUM_BIT, 16: element width, signed two's complement
- NUM_DIM, 8: elements per result vector, ≥2
- IDX_W, $clog2(NUM_DIM): element index width
- i_clk_topMvm  in  1  clock
- i_rst_topMvm  in  1  reset, asynchronous, active-high
- i_isAcc  in  1  accumulator busy flag; 1 while accumulating, 0 when the result is final
- i_y_vector  in  NUM_BIT × [NUM_DIM]  accumulated result, valid while i_isAcc=0
- i_bias  in  NUM_BIT × [NUM_DIM]  per-element bias, sampled at capture
- i_relu_en  in  1  ReLU enable, sampled at capture
- i_ready  in  1  downstream ready
- i_clear_overrun  in  1  synchronous clear of o_overrun
- o_data  out  NUM_BIT  current output element
- o_valid  out  1  o_data/o_idx/o_last valid
- o_idx  out  IDX_W  index of current element
- o_last  out  1  current element is index NUM_DIM-1
- o_busy  out  1  vector held, not fully drained
- o_overrun  out  1  sticky; a result arrived while busy and was dropped

## Operation
- Done detect: registered isAcc_d, reset value 0. A capture event is isAcc_d=1 and i_isAcc=0 at a rising edge. Because isAcc_d resets to 0, a low i_isAcc straight out of reset does not trigger a capture.
- States: IDLE and STREAM (2-bit encoding, spare code returns to IDLE).
- IDLE + capture event:
  - Load the buffer with post-processed elements.
  - Clear the index.
  - Go to STREAM.
- STREAM:
  - o_valid=1 and o_data=buf[idx].
  - A transfer happens when o_valid and i_ready are both 1 at a rising edge. On a transfer, idx increments.
  - A transfer with idx=NUM_DIM-1 returns the block to IDLE.
- Capture event while in STREAM:
  - The vector is dropped and o_overrun is set.
  - This holds even in the cycle of the last transfer; captures are accepted only in IDLE.
- o_overrun:
  - Stays set until i_clear_overrun.
  - If set and clear fall in the same cycle, set wins.
- Per-element arithmetic:
  - s = sext(y) + sext(bias), computed in NUM_BIT+1 bits.
  - Saturate s to [-2^(NUM_BIT-1), 2^(NUM_BIT-1)-1].
  - If relu_en and the result is negative, output 0.
- Outputs hold stable while o_valid=1 and i_ready=0.
- Reset (any time, including mid-stream):
  - State IDLE, idx 0, isAcc_d 0, buffer 0.
  - o_valid, o_last, o_busy and o_overrun all 0; o_data 0 and o_idx 0.
  - No partial vector resumes after reset.

## Timing
- Capture latency: the capture event is sampled at edge N; o_valid=1 with element 0 after edge N.
- Throughput: 1 element/cycle with i_ready held high. A full vector drains in NUM_DIM cycles.
- o_busy equals the STREAM state. It falls after the edge that accepts the last element.
- The earliest next capture is the edge after the last transfer, so the upstream done pulse must come at least one cycle after the drain completes. A done that arrives earlier is counted as an overrun.
- o_last is combinational from registered idx. No combinational path runs from i_ready to o_valid.

## Structure
- Package mvm_pkg holds:
  - NUM_BIT and NUM_DIM defaults.
  - typedef elem_t = logic signed [NUM_BIT-1:0].
  - The state enum {IDLE, STREAM}.
  - Function sat_add(elem_t a, elem_t b).
- Sub-module mvm_post_elem is combinational: bias add, saturate, ReLU. It is instantiated NUM_DIM times in a generate loop feeding the buffer load.
- Top-level mvm_result_drain holds:
  - The edge detect.
  - The FSM.
  - The index counter.
  - The buffer register array.
  - The overrun flag.

## Test plan
Bench uses NUM_BIT=16, NUM_DIM=4.
- Basic drain:
  - Stimulus: i_isAcc 1→0 with y={100,-5,7,0}, bias={-30,0,3,0}, relu off, i_ready=1.
  - Response: o_data 70,-5,10,0 on 4 consecutive cycles; o_idx 0..3; o_last only on idx 3; o_busy falls after.
- Saturation and ReLU:
  - Stimulus: y={32767,-32768,-32768,-5}, bias={10,-1,-1,0}, relu off, then the same vector again with relu on.
  - Response: relu off gives 32767,-32768,-32768,-5. Relu on gives 32767,0,0,0.
- Backpressure:
  - Stimulus: i_ready low for 3 cycles after capture, then toggling 1,0,1,0.
  - Response: o_data/o_idx stay stable while i_ready=0; each element is delivered exactly once, in order; no element is skipped.
- Overrun:
  - Stimulus: a second 1→0 on i_isAcc while idx=1, then i_clear_overrun, then a second 1→0 in the same cycle as i_clear_overrun.
  - Response: the first vector drains unchanged and o_overrun=1. The clear drops o_overrun to 0. Set-and-clear in the same cycle leaves o_overrun at 1.
- Reset behaviour:
  - Stimulus: i_isAcc=0 held through and after reset deassertion; then an async reset pulse mid-stream at idx=2.
  - Response: no capture after reset while i_isAcc stays 0. The mid-stream reset drops o_valid immediately, with all outputs 0. A fresh 1→0 event starts again at idx 0.
